adc_spi_responder: RTL
======================

# adc_spi_responder

Synthesizable dual-channel emulator of the pixel-path serial ADCs: responds to the capture logic's shared `CS`/`SCLK` pair and drives the `px0_adc_din`/`px1_adc_din` lines with known 16-bit frames. It lets the ADC capture path, FIFO and PSRAM write path be checked end-to-end in simulation or on hardware with real sensors disconnected. It is the responding end of the existing ADC capture interface.

## Interface
- `SYNC_STAGES`, 2: input synchronizer depth for `CS`/`SCLK`; legal range 2–3.
- `RAMP_SEED1`, 12'h800: ramp start value for channel 1; channel 0 ramp starts at 0.
- `CLK50`  in  1  system clock; all logic in this domain.
- `MSS_RESET_N`  in  1  reset, asynchronous assert, active-low.
- `CS`  in  1  chip select from capture master, active-low, asynchronous to `CLK50`.
- `SCLK`  in  1  serial clock from capture master; idle high; asynchronous.
- `pattern_mode`  in  2  0 = constant, 1 = ramp, 2 = ch1 is bitwise inverse of ch0 ramp, 3 = reserved (behaves as 0).
- `const0`, `const1`  in  12 each  constant-mode sample values.
- `px0_adc_din`, `px1_adc_din`  out  1 each  serial data to capture master.
- `frame_done`  out  1  one-cycle pulse on each completed 16-bit frame.
- `frame_count`  out  16  completed frames since reset; wraps.
- `abort_count`  out  8  frames ended early by `CS` rising; saturates at 255.

## Operation
- Reset values: `px0_adc_din` = `px1_adc_din` = 0, `frame_done` = 0, `frame_count` = 0, `abort_count` = 0, ramps = 0 / `RAMP_SEED1`, FSM = IDLE.
- `CS` and `SCLK` pass through `SYNC_STAGES` flops, then one edge-detect register. All behaviour is keyed on the synchronized edges.
- Frame format, per channel: 4 leading zeros, then 12 data bits, MSB first; 16 bits in total.
- FSM states and transitions:
  - IDLE → LOAD on `CS` falling edge.
  - LOAD (one cycle): latch `pattern_mode` and both samples into the 16-bit shift registers; drive bit 15 (always 0); bit index = 15; go to SHIFT.
  - SHIFT: each `SCLK` falling edge decrements the index and drives the next bit.
  - SHIFT → DONE on the 15th falling edge after LOAD, i.e. once bit 0 has been presented. At the next (16th) falling edge, drive 0, pulse `frame_done`, increment `frame_count`, and advance the ramps.
  - DONE: data held at 0; extra `SCLK` edges are ignored. DONE → IDLE on `CS` rising edge.
  - SHIFT → IDLE on `CS` rising edge before the 16th falling edge: this is an abort. Drive 0, increment `abort_count` (saturating), no `frame_done`, ramps not advanced.
- Sample sources:
  - Mode 0: `const0`/`const1`.
  - Mode 1: ramp0/ramp1.
  - Mode 2: ramp0 and ~ramp0.
- Ramps are 12-bit, +1 per completed frame, 4095 wraps to 0.
- `pattern_mode` and constants are sampled only in LOAD. Changes mid-frame take effect on the next frame.
- `CS` high in IDLE: outputs driven 0 (no tri-state).
- Simultaneous `CS` rising and `SCLK` falling in the same synchronized cycle: `CS` wins, and the frame is an abort unless the 16th edge was already counted.
- `CS` falling while in DONE is impossible without a `CS` rise in between. An edge-detect glitch here is treated as a `CS` rise followed by re-entry on the next cycle.
- Reset mid-frame: immediate return to reset values; the next `CS` falling edge starts a clean frame.

## Timing
- Data update latency: a `SCLK` or `CS` pin edge reaches `px*_adc_din` in `SYNC_STAGES`+1 `CLK50` cycles (3 by default). For `CS` falling, add one more cycle for LOAD (4 total).
- Master requirement: `SCLK` high and low phases ≥ 4 `CLK50` cycles each, so ≤ 6.25 MHz at 50 MHz. Master samples on the `SCLK` rising edge.
- `CS` falling to first `SCLK` falling: ≥ 6 `CLK50` cycles.
- `frame_done` asserts in the same cycle the 16th falling edge is detected; `frame_count` updates in that cycle too.
- Both channels are bit-aligned: they update in the same `CLK50` cycle.

## Test plan
- Mode 0, `const0`=12'hA5C, `const1`=12'h3F1, one 16-clock frame at `SCLK` = CLK50/8 → master sees 16'h0A5C / 16'h03F1, one `frame_done` pulse, `frame_count`=1.
- Mode 1, 4100 back-to-back frames → ch0 reads 0,1,…,4095,0,…,3; ch1 starts 2048 and wraps 4095→0; `frame_count`=4100.
- Mode 2, 3 frames → ch1 = ~ch0 each frame (16'h0FFF, 16'h0FFE, 16'h0FFD).
- Abort: `CS` rises after 9 falling edges → no `frame_done`, `abort_count`=1, next frame repeats the same ramp value. 260 aborts → `abort_count` saturates at 255.
- 20 `SCLK` falling edges in one frame → bits after the 16th read 0, a single `frame_done` pulse, `frame_count` +1.
- `MSS_RESET_N` low mid-frame (after bit 7) → outputs 0 within the reset assertion, counters 0. A frame after release is correct, starting at ramp value 0.

Source files
------------

// File: rtl/adc_spi_responder_if.sv
// Serial ADC pin bundle shared by the capture master and the ADC responder.
// Ports: CS (active-low chip select), SCLK (idle-high serial clock),
//        px0_adc_din / px1_adc_din (per-channel serial data back to the master).
interface adc_spi_responder_if;
  logic CS;
  logic SCLK;
  logic px0_adc_din;
  logic px1_adc_din;

  // Capture side: drives CS/SCLK, receives data.
  modport master (
    output CS,
    output SCLK,
    input  px0_adc_din,
    input  px1_adc_din
  );

  // ADC side: receives CS/SCLK, drives data.
  modport slave (
    input  CS,
    input  SCLK,
    output px0_adc_din,
    output px1_adc_din
  );
endinterface

// File: rtl/adc_spi_responder.sv
// Dual-channel serial ADC emulator for the pixel path. Answers the capture
// master's CS/SCLK pair with 16-bit frames (4 zeros + 12 data bits, MSB first)
// on both channels, bit-aligned, from constant or ramp patterns.
// Ports:
//   CLK50        system clock, all logic in this domain
//   MSS_RESET_N  asynchronous active-low reset
//   spi          CS/SCLK in, px0_adc_din/px1_adc_din out (slave modport)
//   pattern_mode 0 const, 1 ramp, 2 ch1 = ~ch0 ramp, 3 same as 0
//   const0/1     constant-mode samples
//   frame_done   one-cycle pulse per completed frame
//   frame_count  completed frames since reset (wraps)
//   abort_count  frames cut short by CS rising (saturates)
module adc_spi_responder #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [11:0] RAMP_SEED1  = 12'h800
) (
  input  logic                       CLK50,
  input  logic                       MSS_RESET_N,
  adc_spi_responder_if.slave         spi,
  input  logic [1:0]                 pattern_mode,
  input  logic [11:0]                const0,
  input  logic [11:0]                const1,
  output logic                       frame_done,
  output logic [15:0]                frame_count,
  output logic [7:0]                 abort_count
);

  localparam int unsigned DATA_W  = 12;
  localparam int unsigned FRAME_W = 16;
  localparam int unsigned IDX_W   = 4;
  localparam int unsigned FCNT_W  = 16;
  localparam int unsigned ACNT_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // Input synchronizers and edge detection
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic                   r_cs_d;
  logic                   r_sclk_d;
  logic                   w_cs_s;
  logic                   w_sclk_s;
  logic                   w_cs_fall;
  logic                   w_cs_rise;
  logic                   w_sclk_fall;

  // Reset to the idle-high level so reset release never looks like an edge.
  always_ff @(posedge CLK50 or negedge MSS_RESET_N) begin
    if (!MSS_RESET_N) begin
      r_cs_sync   <= '1;
      r_sclk_sync <= '1;
      r_cs_d      <= 1'b1;
      r_sclk_d    <= 1'b1;
    end else begin
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], spi.CS};
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], spi.SCLK};
      r_cs_d      <= w_cs_s;
      r_sclk_d    <= w_sclk_s;
    end
  end

  assign w_cs_s      = r_cs_sync[SYNC_STAGES-1];
  assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
  assign w_cs_fall   = r_cs_d & ~w_cs_s;
  assign w_cs_rise   = ~r_cs_d & w_cs_s;
  assign w_sclk_fall = r_sclk_d & ~w_sclk_s;

  // ---------------------------------------------------------------------------
  // Pattern source selection (only consumed in LOAD)
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] r_ramp0;
  logic [DATA_W-1:0] r_ramp1;
  logic [DATA_W-1:0] w_samp0;
  logic [DATA_W-1:0] w_samp1;

  always_comb begin
    w_samp0 = const0;
    w_samp1 = const1;
    case (pattern_mode)
      2'd1: begin
        w_samp0 = r_ramp0;
        w_samp1 = r_ramp1;
      end
      2'd2: begin
        w_samp0 = r_ramp0;
        w_samp1 = ~r_ramp0;
      end
      default: begin
        w_samp0 = const0;
        w_samp1 = const1;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Frame FSM and datapath registers
  // ---------------------------------------------------------------------------
  state_t             r_state;
  state_t             w_state_nxt;
  logic [FRAME_W-1:0] r_sh0;
  logic [FRAME_W-1:0] r_sh1;
  logic [FRAME_W-1:0] w_sh0_nxt;
  logic [FRAME_W-1:0] w_sh1_nxt;
  logic [IDX_W-1:0]   r_idx;
  logic [IDX_W-1:0]   w_idx_nxt;
  logic               r_px0;
  logic               r_px1;
  logic               w_px0_nxt;
  logic               w_px1_nxt;
  logic               r_frame_done;
  logic               w_frame_done_nxt;
  logic [FCNT_W-1:0]  r_frame_count;
  logic [FCNT_W-1:0]  w_frame_count_nxt;
  logic [ACNT_W-1:0]  r_abort_count;
  logic [ACNT_W-1:0]  w_abort_count_nxt;
  logic [DATA_W-1:0]  w_ramp0_nxt;
  logic [DATA_W-1:0]  w_ramp1_nxt;

  // State and datapath registers.
  always_ff @(posedge CLK50 or negedge MSS_RESET_N) begin
    if (!MSS_RESET_N) begin
      r_state       <= ST_IDLE;
      r_sh0         <= '0;
      r_sh1         <= '0;
      r_idx         <= '0;
      r_px0         <= 1'b0;
      r_px1         <= 1'b0;
      r_frame_done  <= 1'b0;
      r_frame_count <= '0;
      r_abort_count <= '0;
      r_ramp0       <= '0;
      r_ramp1       <= RAMP_SEED1;
    end else begin
      r_state       <= w_state_nxt;
      r_sh0         <= w_sh0_nxt;
      r_sh1         <= w_sh1_nxt;
      r_idx         <= w_idx_nxt;
      r_px0         <= w_px0_nxt;
      r_px1         <= w_px1_nxt;
      r_frame_done  <= w_frame_done_nxt;
      r_frame_count <= w_frame_count_nxt;
      r_abort_count <= w_abort_count_nxt;
      r_ramp0       <= w_ramp0_nxt;
      r_ramp1       <= w_ramp1_nxt;
    end
  end

  // Next-state and next-output logic.
  // The shift registers hold the not-yet-driven bits left-aligned: bit 15 of
  // the frame goes straight out in LOAD, so they are preloaded with frame<<1.
  // r_idx counts down from 15; a falling edge seen at index 0 is the 16th.
  always_comb begin
    w_state_nxt       = r_state;
    w_sh0_nxt         = r_sh0;
    w_sh1_nxt         = r_sh1;
    w_idx_nxt         = r_idx;
    w_px0_nxt         = r_px0;
    w_px1_nxt         = r_px1;
    w_frame_done_nxt  = 1'b0;
    w_frame_count_nxt = r_frame_count;
    w_abort_count_nxt = r_abort_count;
    w_ramp0_nxt       = r_ramp0;
    w_ramp1_nxt       = r_ramp1;

    case (r_state)
      ST_IDLE: begin
        w_px0_nxt = 1'b0;
        w_px1_nxt = 1'b0;
        if (w_cs_fall) begin
          w_state_nxt = ST_LOAD;
        end
      end

      ST_LOAD: begin
        w_px0_nxt = 1'b0;
        w_px1_nxt = 1'b0;
        if (w_cs_rise) begin
          w_state_nxt = ST_IDLE;
          if (r_abort_count != {ACNT_W{1'b1}}) begin
            w_abort_count_nxt = ACNT_W'(r_abort_count + 1'b1);
          end
        end else begin
          w_sh0_nxt   = {3'b000, w_samp0, 1'b0};
          w_sh1_nxt   = {3'b000, w_samp1, 1'b0};
          w_idx_nxt   = IDX_W'(FRAME_W - 1);
          w_state_nxt = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        // CS rising takes priority over a coincident SCLK falling edge.
        if (w_cs_rise) begin
          w_px0_nxt   = 1'b0;
          w_px1_nxt   = 1'b0;
          w_state_nxt = ST_IDLE;
          if (r_abort_count != {ACNT_W{1'b1}}) begin
            w_abort_count_nxt = ACNT_W'(r_abort_count + 1'b1);
          end
        end else if (w_sclk_fall) begin
          if (r_idx == '0) begin
            w_px0_nxt         = 1'b0;
            w_px1_nxt         = 1'b0;
            w_frame_done_nxt  = 1'b1;
            w_frame_count_nxt = FCNT_W'(r_frame_count + 1'b1);
            w_ramp0_nxt       = DATA_W'(r_ramp0 + 1'b1);
            w_ramp1_nxt       = DATA_W'(r_ramp1 + 1'b1);
            w_state_nxt       = ST_DONE;
          end else begin
            w_px0_nxt = r_sh0[FRAME_W-1];
            w_px1_nxt = r_sh1[FRAME_W-1];
            w_sh0_nxt = {r_sh0[FRAME_W-2:0], 1'b0};
            w_sh1_nxt = {r_sh1[FRAME_W-2:0], 1'b0};
            w_idx_nxt = IDX_W'(r_idx - 1'b1);
          end
        end
      end

      ST_DONE: begin
        w_px0_nxt = 1'b0;
        w_px1_nxt = 1'b0;
        if (w_cs_rise) begin
          w_state_nxt = ST_IDLE;
        end else if (w_cs_fall) begin
          // A fall without a seen rise: close this frame and start the next.
          w_state_nxt = ST_LOAD;
        end
      end

      default: begin
        w_px0_nxt   = 1'b0;
        w_px1_nxt   = 1'b0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign spi.px0_adc_din = r_px0;
  assign spi.px1_adc_din = r_px1;
  assign frame_done      = r_frame_done;
  assign frame_count     = r_frame_count;
  assign abort_count     = r_abort_count;

endmodule
